// File: rtl/sdram_seq_68k.sv
// sdram_seq_68k: sequences 68000 bus cycles into single-word SDRAM accesses, with power-up init and auto refresh
// Ports: CLK, RST (synchronous, active-high); AS, RW, UDS, LDS, A[23:1] from the 68k bus;
//        MA, BA, DQM, RAS, CAS, RAMWE, CKE drive the SDRAM; VALID (active-low access done), READY (init done).
// Define SDRAM_AUTOPRE_EN to close rows with auto-precharge instead of an explicit PRECHARGE command.
// T_RCD, T_RP and T_RC must be at least 2; CAS_LAT must be 2 or 3.
module sdram_seq_68k #(
  parameter int T_RCD     = 2,
  parameter int CAS_LAT   = 2,
  parameter int T_RP      = 2,
  parameter int T_RC      = 6,
  parameter int REF_INT   = 500,
  parameter int INIT_WAIT = 10000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AS,
  input  logic        RW,
  input  logic        UDS,
  input  logic        LDS,
  input  logic [23:1] A,
  output logic [12:0] MA,
  output logic [1:0]  BA,
  output logic [1:0]  DQM,
  output logic        RAS,
  output logic        CAS,
  output logic        RAMWE,
  output logic        CKE,
  output logic        VALID,
  output logic        READY
);
  localparam int CW  = $clog2(INIT_WAIT + T_RC + T_RP + T_RCD + CAS_LAT + 2);
  localparam int RCW = $clog2(REF_INT + 1);
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_READ = 3'b101, C_WRITE = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;
  localparam logic [12:0] MODE = {6'b000000, 3'(CAS_LAT), 4'b0000};
`ifdef SDRAM_AUTOPRE_EN
  localparam logic AP = 1'b1;
`else
  localparam logic AP = 1'b0;
`endif
  typedef enum logic [3:0] {
    INIT_NOP, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, REFRESH, ACTIVATE, ACCESS, CAS_WAIT, HOLD
`ifndef SDRAM_AUTOPRE_EN
    , PRECHARGE
`endif
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RCW-1:0] ref_q, ref_d;
  logic [2:0] cmd_q, cmd_d;
  logic [12:0] ma_q, ma_d;
  logic [1:0] ba_q, ba_d, dqm_q, dqm_d;
  logic pend_q, pend_d, arm_q, arm_d, rw_q, rw_d, valid_q, valid_d, ready_q, ready_d, cke_q, cke_d;
  logic done, wrap;
  assign done = cnt_q == '0;
  assign wrap = ref_q == RCW'(REF_INT - 1);
  // arm records that AS has been seen high since the last ACTIVATE: it gates new accesses
  // (one per AS assertion) and marks an access as aborted so VALID is never driven.
  always_comb begin
    state_d = state_q;
    cnt_d   = done ? cnt_q : cnt_q - 1'b1;
    ref_d   = ready_q ? (wrap ? '0 : ref_q + 1'b1) : ref_q;
    pend_d  = pend_q | (ready_q & wrap);
    arm_d   = arm_q | AS;
    rw_d    = rw_q;
    cmd_d   = C_NOP;
    ma_d    = ma_q;
    ba_d    = ba_q;
    dqm_d   = dqm_q;
    valid_d = 1'b1;
    ready_d = ready_q;
    cke_d   = 1'b1;
    case (state_q)
      INIT_NOP: if (done) begin
        cmd_d = C_PRE; ma_d = 13'h0400; cnt_d = CW'(T_RP - 1); state_d = INIT_PRE;
      end
      INIT_PRE: if (done) begin
        cmd_d = C_REF; cnt_d = CW'(T_RC - 1); state_d = INIT_REF1;
      end
      INIT_REF1: if (done) begin
        cmd_d = C_REF; cnt_d = CW'(T_RC - 1); state_d = INIT_REF2;
      end
      INIT_REF2: if (done) begin
        cmd_d = C_MRS; ma_d = MODE; ba_d = 2'b00; cnt_d = CW'(1); state_d = INIT_MRS;
      end
      INIT_MRS: if (done) begin
        ready_d = 1'b1; state_d = IDLE;
      end
      IDLE: if (done && pend_q) begin
        cmd_d = C_REF; pend_d = wrap; cnt_d = CW'(T_RC - 2); state_d = REFRESH;
      end else if (done && arm_q && !AS) begin
        cmd_d = C_ACT; ma_d = {1'b0, A[23:12]}; ba_d = A[11:10]; rw_d = RW; arm_d = 1'b0;
        cnt_d = CW'(T_RCD - 2); state_d = ACTIVATE;
      end
      REFRESH:  if (done) state_d = IDLE;
      ACTIVATE: if (done) state_d = ACCESS;
      ACCESS: begin
        ma_d = {2'b00, AP, 1'b0, A[9:1]};
        if (rw_q) begin
          cmd_d = C_READ; dqm_d = 2'b00; cnt_d = CW'(CAS_LAT - 2); state_d = CAS_WAIT;
        end else if (arm_q || AS) begin
          // aborted write: a fully masked WRITE keeps the row-closing path identical
          cmd_d = C_WRITE; dqm_d = 2'b11; state_d = HOLD;
        end else if (!UDS || !LDS) begin
          cmd_d = C_WRITE; dqm_d = {UDS, LDS}; state_d = HOLD;
        end
      end
      CAS_WAIT: if (done) state_d = HOLD;
      HOLD: if (AS || arm_q) begin
`ifdef SDRAM_AUTOPRE_EN
        cnt_d = CW'(T_RP - 1); state_d = IDLE;
`else
        cmd_d = C_PRE; ma_d = 13'h0000; cnt_d = CW'(T_RP - 2); state_d = PRECHARGE;
`endif
      end else valid_d = 1'b0;
`ifndef SDRAM_AUTOPRE_EN
      PRECHARGE: if (done) state_d = IDLE;
`endif
      default: state_d = INIT_NOP;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= INIT_NOP;
      cnt_q   <= CW'(INIT_WAIT - 1);
      ref_q   <= '0;
      pend_q  <= 1'b0;
      arm_q   <= 1'b0;
      rw_q    <= 1'b0;
      cmd_q   <= C_NOP;
      ma_q    <= '0;
      ba_q    <= '0;
      dqm_q   <= 2'b11;
      valid_q <= 1'b1;
      ready_q <= 1'b0;
      cke_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      pend_q  <= pend_d;
      arm_q   <= arm_d;
      rw_q    <= rw_d;
      cmd_q   <= cmd_d;
      ma_q    <= ma_d;
      ba_q    <= ba_d;
      dqm_q   <= dqm_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      cke_q   <= cke_d;
    end
  end
  assign {RAS, CAS, RAMWE} = cmd_q;
  assign MA    = ma_q;
  assign BA    = ba_q;
  assign DQM   = dqm_q;
  assign CKE   = cke_q;
  assign VALID = valid_q;
  assign READY = ready_q;
endmodule

// File: tb/tb_sdram_seq_68k.sv
// tb_sdram_seq_68k: directed self-checking bench for sdram_seq_68k
module tb_sdram_seq_68k;
  localparam int T_RCD = 2, CAS_LAT = 2, T_RP = 2, T_RC = 6, REF_INT = 500, INIT_WAIT = 10000;
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_READ = 3'b101, C_WRITE = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;
  // row 12'h123, bank 01, column 9'h056
  localparam logic [23:1] ADDR = {12'h123, 2'b01, 9'h056};
  logic CLK, RST, AS, RW, UDS, LDS;
  logic [23:1] A;
  logic [12:0] MA;
  logic [1:0] BA, DQM;
  logic RAS, CAS, RAMWE, CKE, VALID, READY;
  logic [2:0] cmd;
  logic vlow, seen;
  int n_chk = 0, n_fail = 0;
  assign cmd = {RAS, CAS, RAMWE};
  sdram_seq_68k #(
    .T_RCD(T_RCD), .CAS_LAT(CAS_LAT), .T_RP(T_RP), .T_RC(T_RC), .REF_INT(REF_INT), .INIT_WAIT(INIT_WAIT)
  ) dut (
    .CLK(CLK), .RST(RST), .AS(AS), .RW(RW), .UDS(UDS), .LDS(LDS), .A(A),
    .MA(MA), .BA(BA), .DQM(DQM), .RAS(RAS), .CAS(CAS), .RAMWE(RAMWE),
    .CKE(CKE), .VALID(VALID), .READY(READY)
  );
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  task automatic step();
    @(negedge CLK);
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_cmd"}, 32'(cmd), 32'(C_NOP));
    check({tag, "_ma"}, 32'(MA), 32'h0);
    check({tag, "_ba"}, 32'(BA), 32'h0);
    check({tag, "_dqm"}, 32'(DQM), 32'h3);
    check({tag, "_cke"}, 32'(CKE), 32'h0);
    check({tag, "_valid"}, 32'(VALID), 32'h1);
    check({tag, "_ready"}, 32'(READY), 32'h0);
  endtask
  // releases reset and follows the whole init sequence; a request pulsed mid-wait must be ignored
  task automatic init_seq();
    int n = 0;
    logic vl = 1'b0;
    RST = 1'b0;
    while (cmd == C_NOP && n < INIT_WAIT + 100) begin
      if (n == 100) AS = 1'b0;
      if (n == 200) AS = 1'b1;
      step();
      n++;
      vl |= !VALID;
    end
    check("init_nop_len", 32'(n), 32'(INIT_WAIT));
    check("init_pre", 32'(cmd), 32'(C_PRE));
    check("init_pre_ma10", 32'(MA[10]), 32'h1);
    check("init_cke", 32'(CKE), 32'h1);
    repeat (T_RP) step();
    check("init_ref1", 32'(cmd), 32'(C_REF));
    repeat (T_RC) step();
    check("init_ref2", 32'(cmd), 32'(C_REF));
    repeat (T_RC) step();
    check("init_mrs", 32'(cmd), 32'(C_MRS));
    check("init_mrs_ma", 32'(MA), 32'h020);
    check("init_not_ready", 32'(READY), 32'h0);
    repeat (2) step();
    check("init_ready", 32'(READY), 32'h1);
    check("init_valid_idle", 32'(vl), 32'h0);
  endtask
  // waits for an auto refresh, then for its T_RC gap so the next access is not disturbed
  task automatic sync_ref();
    int n = 0;
    while (cmd != C_REF && n < 2 * REF_INT) begin
      step();
      n++;
    end
    check("ref_sync", 32'(cmd == C_REF), 32'h1);
    repeat (T_RC) step();
  endtask
  initial begin
    RST = 1'b1; AS = 1'b1; RW = 1'b1; UDS = 1'b1; LDS = 1'b1; A = ADDR;
    repeat (3) step();
    check_reset("rst");
    init_seq();
    sync_ref();
    AS = 1'b0; RW = 1'b1;
    step();
    check("rd_act", 32'(cmd), 32'(C_ACT));
    check("rd_row", 32'(MA), 32'h0123);
    check("rd_ba", 32'(BA), 32'h1);
    step();
    check("rd_gap", 32'(cmd), 32'(C_NOP));
    step();
    check("rd_cmd", 32'(cmd), 32'(C_READ));
    check("rd_col", 32'(MA), 32'h056);
    check("rd_dqm", 32'(DQM), 32'h0);
    step();
    check("rd_valid_early", 32'(VALID), 32'h1);
    step();
    check("rd_valid", 32'(VALID), 32'h0);
    repeat (2) step();
    check("rd_hold", 32'(VALID), 32'h0);
    AS = 1'b1;
    step();
    check("rd_release", 32'(VALID), 32'h1);
    check("rd_pre", 32'(cmd), 32'(C_PRE));
    check("rd_pre_ma10", 32'(MA[10]), 32'h0);
    check("rd_pre_ba", 32'(BA), 32'h1);
    sync_ref();
    AS = 1'b0; RW = 1'b0;
    repeat (3) step();
    check("wr_wait", 32'(cmd), 32'(C_NOP));
    LDS = 1'b0;
    step();
    check("wr_cmd", 32'(cmd), 32'(C_WRITE));
    check("wr_dqm", 32'(DQM), 32'h2);
    check("wr_col", 32'(MA), 32'h056);
    step();
    check("wr_valid", 32'(VALID), 32'h0);
    AS = 1'b1; LDS = 1'b1; RW = 1'b1;
    step();
    check("wr_release", 32'(VALID), 32'h1);
    check("wr_pre", 32'(cmd), 32'(C_PRE));
    sync_ref();
    AS = 1'b0; RW = 1'b1;
    step();
    check("ab_act", 32'(cmd), 32'(C_ACT));
    AS = 1'b1;
    repeat (2) step();
    check("ab_read", 32'(cmd), 32'(C_READ));
    vlow = 1'b0; seen = 1'b0;
    repeat (6) begin
      step();
      vlow |= !VALID;
      seen |= (cmd == C_PRE);
    end
    check("ab_valid_high", 32'(vlow), 32'h0);
    check("ab_pre", 32'(seen), 32'h1);
    AS = 1'b0;
    step();
    check("ab_idle_act", 32'(cmd), 32'(C_ACT));
    AS = 1'b1;
    repeat (10) step();
    sync_ref();
    repeat (REF_INT - T_RC - 1) step();
    AS = 1'b0; RW = 1'b1;
    step();
    check("col_ref", 32'(cmd), 32'(C_REF));
    repeat (T_RC - 1) step();
    check("col_gap", 32'(cmd), 32'(C_NOP));
    step();
    check("col_act", 32'(cmd), 32'(C_ACT));
    repeat (T_RCD + CAS_LAT) step();
    check("col_valid", 32'(VALID), 32'h0);
    AS = 1'b1;
    step();
    check("col_release", 32'(VALID), 32'h1);
    sync_ref();
    AS = 1'b0; RW = 1'b1;
    repeat (3) step();
    check("rc_read", 32'(cmd), 32'(C_READ));
    RST = 1'b1;
    step();
    check_reset("rc");
    AS = 1'b1;
    init_seq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
